// File: rtl/pc_stack_unit.sv
// Program counter with increment, jump, relative branch and call/return
// through an internal return-address stack with sticky misuse flags.
module pc_stack_unit #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned RESET_ADDR = 0,
    parameter int unsigned INC        = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             en,
    input  logic [2:0]                       op,
    input  logic [WIDTH-1:0]                 target,
    input  logic [WIDTH-1:0]                 offset,
    input  logic                             clr_err,
    output logic [WIDTH-1:0]                 pc,
    output logic [WIDTH-1:0]                 top,
    output logic [$clog2(DEPTH+1)-1:0]       sp,
    output logic                             ovf,
    output logic                             udf
);

    localparam int unsigned SP_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_INC    = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_CALL   = 3'd4;
    localparam logic [2:0] OP_RET    = 3'd5;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SP_W-1:0]  sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [WIDTH-1:0] stack_q [DEPTH];

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] top_val;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] push_idx;
    logic             push;
    logic             stack_full;
    logic             stack_empty;

    assign pc_inc      = pc_q + WIDTH'(INC);
    assign stack_full  = (sp_q == SP_W'(DEPTH));
    assign stack_empty = (sp_q == '0);
    assign top_idx     = IDX_W'(sp_q - SP_W'(1));
    assign push_idx    = IDX_W'(sp_q);
    assign top_val     = stack_empty ? '0 : stack_q[top_idx];

    // Next-state: one op per cycle; flag set takes priority over clear.
    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        ovf_d = ovf_q & ~clr_err;
        udf_d = udf_q & ~clr_err;
        push  = 1'b0;
        if (en) begin
            case (op)
                OP_INC:    pc_d = pc_inc;
                OP_JUMP:   pc_d = target;
                OP_BRANCH: pc_d = pc_q + offset;
                OP_CALL: begin
                    pc_d = target;
                    if (stack_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + SP_W'(1);
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        pc_d  = pc_inc;
                        udf_d = 1'b1;
                    end else begin
                        pc_d = top_val;
                        sp_d = sp_q - SP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q  <= WIDTH'(RESET_ADDR);
            sp_q  <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Entry storage needs no reset; sp alone defines validity.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign pc  = pc_q;
    assign sp  = sp_q;
    assign top = top_val;
    assign ovf = ovf_q;
    assign udf = udf_q;

endmodule
